// File: rtl/mux_pkg.sv
// Shared definitions for the mux family: default sizes and the select-width helper.
package mux_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_N_ENTRADAS = 4;

    // Bits needed to index n inputs; never less than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way selector.
//   entradas   : flat bus, input i at [i*WIDTH +: WIDTH]
//   controle   : select index
//   dado       : selected input (zero when out of range)
//   fora_faixa : controle >= N_ENTRADAS
module mux_n_comb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned N_ENTRADAS = DEFAULT_N_ENTRADAS,
    parameter int unsigned SEL_W      = sel_width(N_ENTRADAS)
) (
    input  logic [N_ENTRADAS*WIDTH-1:0] entradas,
    input  logic [SEL_W-1:0]            controle,
    output logic [WIDTH-1:0]            dado,
    output logic                        fora_faixa
);

    localparam int unsigned SW1 = SEL_W + 1;

    // Priority-free decode: at most one index can match.
    always_comb begin
        dado = '0;
        for (int unsigned i = 0; i < N_ENTRADAS; i++) begin
            if (controle == SEL_W'(i)) begin
                dado = entradas[i*WIDTH +: WIDTH];
            end
        end
    end

    // A full power-of-two select space has no illegal codes.
    generate
        if (N_ENTRADAS == (1 << SEL_W)) begin : g_full_range
            assign fora_faixa = 1'b0;
        end else begin : g_partial_range
            assign fora_faixa = ({1'b0, controle} >= SW1'(N_ENTRADAS));
        end
    endgenerate

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-way mux behind a single-stage valid/ready pipeline register.
//   clock, reset_n        : rising-edge clock, async active-low reset
//   entradas, controle    : data inputs and select, offered with in_valid
//   in_valid / in_ready   : upstream handshake (in_ready is combinational)
//   saida, sel_reg        : registered result and the index that produced it
//   out_valid / out_ready : downstream handshake
//   erro, limpa_erro      : sticky out-of-range flag and its synchronous clear
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned N_ENTRADAS = DEFAULT_N_ENTRADAS,
    parameter int unsigned SEL_W      = sel_width(N_ENTRADAS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [N_ENTRADAS*WIDTH-1:0] entradas,
    input  logic [SEL_W-1:0]            controle,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            saida,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SEL_W-1:0]            sel_reg,
    output logic                        erro,
    input  logic                        limpa_erro
);

    logic [WIDTH-1:0] dado_c;
    logic             fora_faixa_c;
    logic             in_xfer_c;
    logic             out_xfer_c;
    logic             load_c;

    mux_n_comb #(
        .WIDTH      (WIDTH),
        .N_ENTRADAS (N_ENTRADAS),
        .SEL_W      (SEL_W)
    ) u_comb (
        .entradas   (entradas),
        .controle   (controle),
        .dado       (dado_c),
        .fora_faixa (fora_faixa_c)
    );

    // Register is free when empty or being drained this cycle.
    assign in_ready   = !out_valid || out_ready;
    assign in_xfer_c  = in_valid && in_ready;
    assign out_xfer_c = out_valid && out_ready;
    // Out-of-range selects are accepted but produce no result.
    assign load_c     = in_xfer_c && !fora_faixa_c;

    // Data path and valid flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saida     <= '0;
            sel_reg   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load_c) begin
                saida     <= dado_c;
                sel_reg   <= controle;
                out_valid <= 1'b1;
            end else if (out_xfer_c) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky error: a new out-of-range transfer wins over the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            erro <= 1'b0;
        end else if (in_xfer_c && fora_faixa_c) begin
            erro <= 1'b1;
        end else if (limpa_erro) begin
            erro <= 1'b0;
        end
    end

endmodule

// File: doc/mux_n_reg.md
MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of every input and of saida.
REQ-002 SHALL have parameter N_ENTRADAS, default 4, legal range 2..16: number of data inputs.
REQ-003 SHALL have parameter SEL_W, default $clog2(N_ENTRADAS): width of controle and sel_reg.
REQ-004 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous reset, active low.
REQ-006 SHALL have port entradas, input, N_ENTRADAS*WIDTH bits: flat bus; input i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port controle, input, SEL_W bits: select index, sampled with in_valid.
REQ-008 SHALL have port in_valid, input, 1 bit: upstream offers entradas/controle.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts this cycle.
REQ-010 SHALL have port saida, output, WIDTH bits: registered selected data.
REQ-011 SHALL have port out_valid, output, 1 bit: saida holds an unconsumed result.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream consumes saida.
REQ-013 SHALL have port sel_reg, output, SEL_W bits: index that produced current saida.
REQ-014 SHALL have port erro, output, 1 bit: sticky out-of-range-select flag.
REQ-015 SHALL have port limpa_erro, input, 1 bit: synchronous clear of erro.

Function
REQ-016 Transfer in SHALL occur when in_valid && in_ready at a rising edge; transfer out when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (single-stage pipeline register, full throughput, combinational back-pressure only).
REQ-018 On an in-transfer with controle < N_ENTRADAS, saida SHALL load input[controle], sel_reg SHALL load controle, and out_valid SHALL be 1 the next cycle; latency is exactly 1 clock.
REQ-019 On an in-transfer with controle >= N_ENTRADAS, saida and sel_reg SHALL keep their values, no new result SHALL be produced (out_valid follows REQ-020 as if no in-transfer), and erro SHALL set to 1.
REQ-020 Without a valid in-transfer, an out-transfer SHALL clear out_valid; without an out-transfer, out_valid and saida SHALL hold.
REQ-021 Simultaneous in-transfer and out-transfer SHALL replace saida with the new result and keep out_valid at 1.
REQ-022 saida SHALL NOT change while out_valid=1 && out_ready=0.
REQ-023 erro SHALL clear when limpa_erro=1; if limpa_erro and a new out-of-range transfer coincide, erro SHALL be 1 (set wins).
REQ-024 When N_ENTRADAS is a power of two, the out-of-range path SHALL be unreachable and erro SHALL remain 0.

Reset
REQ-025 reset_n low SHALL asynchronously force saida=0, sel_reg=0, out_valid=0, erro=0.
REQ-026 in_ready SHALL be 1 during and immediately after reset; a transfer in flight when reset asserts SHALL be discarded.
REQ-027 Deassertion of reset_n SHALL be treated as synchronous to clock by the integrating logic; the block adds no synchroniser.

Structure
REQ-028 Default WIDTH, default N_ENTRADAS and the select-width function SHALL live in the shared package mux_pkg, reused by later mux variants.
REQ-029 The combinational N-way selection SHALL be a sub-module mux_n_comb (entradas, controle -> dado, fora_faixa); mux_n_reg SHALL contain only handshake, registers and error logic.

Verification
REQ-030 Reset: reset_n=0 mid-stream with out_valid=1 -> saida=0, out_valid=0, erro=0, in_ready=1 in the same cycle.
REQ-031 Selection: N=4, WIDTH=32, inputs 0x11111111..0x44444444, controle=2, in_valid=1, out_ready=1 -> next cycle saida=0x33333333, sel_reg=2, out_valid=1.
REQ-032 Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, saida stable across all 3 cycles; out_ready=1 -> one transfer, next result loads.
REQ-033 Streaming: in_valid=out_ready=1 for 8 cycles with controle 0,1,2,3,0,1,2,3 -> 8 results in order, one per cycle, no bubbles.
REQ-034 Error: N=3, controle=3 accepted -> erro=1, saida/sel_reg unchanged, no new result; limpa_erro=1 -> erro=0; limpa_erro coincident with another controle=3 -> erro=1.
REQ-035 Parametrisation: repeat REQ-031 with N=16, WIDTH=8, controle=15 -> saida=input[15].
